// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32M multiply/divide sequencer:
//   XLEN          - datapath width
//   F3_*          - RV32M funct3 encodings (MUL .. REMU)
//   md_state_t    - sequencer FSM states
//   DIV_ZERO_Q    - quotient returned for division by zero (all ones)
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_SETUP,
        S_DIV_ITER,
        S_DIV_FIX,
        S_DONE
    } md_state_t;

    // Division ops with funct3[0]==0 (DIV, REM) are signed.
    function automatic logic div_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Iterative restoring divider datapath on unsigned magnitudes: one
// shift-subtract step per enabled cycle. Sign handling and special cases are
// owned by the sequencer; it may preset quotient/remainder directly through
// quo_init/rem_init so the final fix-up stage always reads from here.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   load                load quo_init/rem_init/divisor, counter = DIV_CYCLES-1
//   en                  perform one restoring step
//   quo_init, rem_init  initial quotient (dividend) and remainder
//   divisor             unsigned divisor magnitude
//   quotient, remainder current register contents
//   last                counter has reached zero (final step this cycle)
// -----------------------------------------------------------------------------
module div_core #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            en,
    input  logic [XLEN-1:0] quo_init,
    input  logic [XLEN-1:0] rem_init,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_next, quo_next;

    // Remainder stays below the divisor, so the shifted value is below
    // 2*divisor and a non-negative difference always fits in XLEN bits.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, dvs_q};
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo_q[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= rem_init;
            quo_q <= quo_init;
            dvs_q <= divisor;
            cnt_q <= CW'(DIV_CYCLES - 1);
        end else if (en) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Sequences one RV32M multiply/divide op from EX: latches operands in IDLE,
// runs a single-cycle registered multiply or a 32-step restoring divide, and
// stalls the front of the pipe until the result is returned with its rd tag.
//
// Ports:
//   clk, reset   clock; synchronous active-low reset
//   start        valid M-extension op in EX (sampled only in IDLE)
//   funct3       RV32M operation
//   op_a, op_b   rs1 / rs2 values (post-forwarding)
//   rd_in        destination register tag
//   flush        kill the in-flight op (no done)
//   stall        freeze PC, IF/ID, ID/EX
//   busy         state != IDLE
//   done         one-cycle pulse, result/rd_out valid
//   result       op result, held until the next done
//   rd_out       tag of the completed op, held with result
//
// Latency (start cycle to done cycle): MUL family 2, division 35, division by
// zero / signed overflow 3.
//
// Optional build macro MULDIV_PAIR_REUSE_EN: remembers the last completed
// division (operands, signedness, quotient, remainder) so a repeated division
// on the same operands completes in 2 cycles.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t       state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [4:0]      rd_q;
    logic            neg_quo_q, neg_rem_q;

    // ---------------------------------------------------------------- multiply
    // Operands are sign- or zero-extended to 2*XLEN; the low 2*XLEN bits of the
    // product of extended operands are the exact signed/unsigned product.
    logic            mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
    logic [XLEN-1:0] mul_res;

    always_comb begin
        mul_sa   = (op_q == F3_MULH) || (op_q == F3_MULHSU);
        mul_sb   = (op_q == F3_MULH);
        mul_a    = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
        mul_b    = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
        mul_full = mul_a * mul_b;
        mul_res  = (op_q == F3_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------ divide
    logic            div_sgn, a_neg, b_neg, div_by_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_load, div_en, div_last;
    logic [XLEN-1:0] quo_init, rem_init, div_quo, div_rem;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic            reuse_hit;
    logic [XLEN-1:0] saved_quo, saved_rem;

    always_comb begin
        div_sgn     = div_is_signed(op_q);
        a_neg       = div_sgn & a_q[XLEN-1];
        b_neg       = div_sgn & b_q[XLEN-1];
        a_abs       = a_neg ? -a_q : a_q;
        b_abs       = b_neg ? -b_q : b_q;
        div_by_zero = (b_q == '0);
        div_ovf     = div_sgn && (a_q == INT_MIN) && (b_q == '1);
        quo_fix     = neg_quo_q ? -div_quo : div_quo;
        rem_fix     = neg_rem_q ? -div_rem : div_rem;
    end

    // Special cases and reuse hits preset the divider registers with the final
    // values and skip iteration, so DIV_FIX is the single result-select point.
    always_comb begin
        div_load = 1'b0;
        div_en   = 1'b0;
        quo_init = a_abs;
        rem_init = '0;
        case (state)
            S_IDLE: begin
                if (start && !flush && reuse_hit) begin
                    div_load = 1'b1;
                    quo_init = saved_quo;
                    rem_init = saved_rem;
                end
            end
            S_DIV_SETUP: begin
                div_load = 1'b1;
                if (div_by_zero) begin
                    quo_init = DIV_ZERO_Q;
                    rem_init = a_q;
                end else if (div_ovf) begin
                    quo_init = INT_MIN;
                    rem_init = '0;
                end
            end
            S_DIV_ITER: div_en = 1'b1;
            default: ;
        endcase
    end

    div_core #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .en        (div_en),
        .quo_init  (quo_init),
        .rem_init  (rem_init),
        .divisor   (b_abs),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // ------------------------------------------------------------- pair reuse
`ifdef MULDIV_PAIR_REUSE_EN
    logic            saved_valid;
    logic [XLEN-1:0] saved_a, saved_b;
    logic            saved_sgn;

    assign reuse_hit = funct3[2] && saved_valid && (op_a == saved_a) &&
                       (op_b == saved_b) && (div_is_signed(funct3) == saved_sgn);

    always_ff @(posedge clk) begin
        if (!reset) begin
            saved_valid <= 1'b0;
            saved_a     <= '0;
            saved_b     <= '0;
            saved_sgn   <= 1'b0;
            saved_quo   <= '0;
            saved_rem   <= '0;
        end else if (flush) begin
            saved_valid <= 1'b0;
        end else if (state == S_DIV_FIX) begin
            saved_valid <= 1'b1;
            saved_a     <= a_q;
            saved_b     <= b_q;
            saved_sgn   <= div_sgn;
            saved_quo   <= quo_fix;
            saved_rem   <= rem_fix;
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign saved_quo = '0;
    assign saved_rem = '0;
`endif

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q <= funct3;
                        a_q  <= op_a;
                        b_q  <= op_b;
                        rd_q <= rd_in;
                        if (reuse_hit) begin
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state     <= S_DIV_FIX;
                        end else begin
                            state <= funct3[2] ? S_DIV_SETUP : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= mul_res;
                        rd_out <= rd_q;
                        state  <= S_DONE;
                    end
                end
                S_DIV_SETUP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (div_by_zero || div_ovf) begin
                        neg_quo_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                        state     <= S_DIV_FIX;
                    end else begin
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        state     <= S_DIV_ITER;
                    end
                end
                S_DIV_ITER: begin
                    if (flush)
                        state <= S_IDLE;
                    else if (div_last)
                        state <= S_DIV_FIX;
                end
                S_DIV_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= op_q[1] ? rem_fix : quo_fix;
                        rd_out <= rd_q;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign stall = ((state == S_IDLE) && start) ||
                   ((state != S_IDLE) && (state != S_DONE));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed vectors with hand-computed results for muldiv_sequencer.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

`ifdef MULDIV_PAIR_REUSE_EN
    localparam int REUSE_LAT     = 2;
    localparam int REUSE_OVF_LAT = 2;
`else
    localparam int REUSE_LAT     = 35;
    localparam int REUSE_OVF_LAT = 3;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            stall, busy, done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one op in cycle 0 and wait (bounded) for done.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(negedge clk);
        check({tag, " stall@0"}, 32'(stall), 32'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            @(negedge clk);
            if (cyc == 1 && !done)
                check({tag, " stall@1"}, 32'(stall), 32'd1);
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, " stall@done"}, 32'(stall), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_res,
                                      input logic [4:0] exp_rd);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " result"}, result, exp_res);
        check({tag, " rd_out"}, 32'(rd_out), 32'(exp_rd));
    endtask

    initial begin
        bit saw_done;

        reset = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        rd_in = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 32'h0, 5'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Multiply family
        do_op("MUL 7*-3",       3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2);
        do_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 2);
        do_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,        5'd7,  32'hFFFF_FFFF, 2);
        do_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, 2);
        do_op("MUL 0x10000^2",  3'b000, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0000_0000, 2);

        // Divide family
        do_op("DIV -20/3",      3'b100, 32'hFFFF_FFEC, 32'd3,        5'd10, 32'hFFFF_FFFA, 35);
        do_op("REM -20/3",      3'b110, 32'hFFFF_FFEC, 32'd3,        5'd11, 32'hFFFF_FFFE, REUSE_LAT);
        do_op("DIVU min/-1",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 35);
        do_op("DIV 5/0",        3'b100, 32'd5,        32'd0,         5'd13, 32'hFFFF_FFFF, 3);
        do_op("REMU 5/0",       3'b111, 32'd5,        32'd0,         5'd14, 32'd5,         3);
        do_op("DIV min/-1",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 3);
        do_op("REM min/-1",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, REUSE_OVF_LAT);
        do_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,         5'd17, 32'd14,        35);
        do_op("REM 100/7",      3'b110, 32'd100,      32'd7,         5'd18, 32'd2,         35);
        do_op("REM 100/7 again",3'b110, 32'd100,      32'd7,         5'd19, 32'd2,         REUSE_LAT);
        do_op("MUL 6*7",        3'b000, 32'd6,        32'd7,         5'd9,  32'd42,        2);

        // flush together with start in IDLE: op must not be accepted
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'b100; op_a = 32'd9; op_b = 32'd2; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+start busy", 32'(busy), 32'd0);

        // flush at cycle 10 of a DIV
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd12;
        saw_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_idle_outputs("flush", 32'd42, 5'd9);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("flush no done", 32'(saw_done), 32'd0);

        // reset mid-DIV
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20;
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("mid reset", 32'h0, 5'd0);
        check("mid reset stall", 32'(stall), 32'd0);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("mid reset no done", 32'(saw_done), 32'd0);

        do_op("MUL 3*5 after reset", 3'b000, 32'd3, 32'd5, 5'd4, 32'd15, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences RV32M multiply/divide ops issued from the EX stage.
- Holds a single operation, runs an iterative radix-2 divider or a registered multiplier, and asserts a stall toward the hazard logic until the result is ready.
- Returns the result with its destination register tag for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width
DIV_CYCLES, 32, divider iterations (equals XLEN)

Ports:
clk  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-low (0 = reset, sampled on posedge clk)
start  input  1  EX holds a valid M-extension op; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (post-forwarding)
op_b  input  XLEN  rs2 value (post-forwarding)
rd_in  input  5  destination register tag
flush  input  1  branch/exception kill; aborts in-flight op
stall  output  1  freeze PC, IF/ID and ID/EX; combinational: start in IDLE, or state != IDLE, and not done this cycle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse; result/rd_out valid
result  output  XLEN  op result; held until next done
rd_out  output  5  tag of completed op; held with result

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, busy=0, done=0, result=0, rd_out=0, divider regs cleared. Reset overrides flush and start; a mid-operation op is discarded with no done.
- States: IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX, DONE.
- IDLE, start=1 and flush=0: latch funct3, op_a, op_b, rd_in. funct3[2]=0 -> MUL, else -> DIV_SETUP. Inputs are ignored outside IDLE.
- MUL (1 cycle):
  - Form a 2*XLEN product with signedness per funct3: MULH s*s, MULHSU s*u, MULHU u*u.
  - MUL selects the low word; the others select the high word. -> DONE.
  - Total latency start->done is 2 cycles.
- DIV_SETUP:
  - Divisor zero: quotient=all ones, remainder=dividend; -> DONE.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0; -> DONE.
  - Otherwise take absolute values (signed ops), clear the remainder, set counter=DIV_CYCLES-1; -> DIV_ITER.
- DIV_ITER: one restoring shift-subtract step per cycle. When counter==0 -> DIV_FIX, else decrement.
- DIV_FIX:
  - Negate the quotient if the operand signs differ (signed op).
  - Negate the remainder if the dividend is negative.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU). -> DONE.
- Division latency: 35 cycles normal, 3 cycles special case (start->done).
- DONE: done=1, result/rd_out update this cycle, stall=0. Next state is IDLE; a new start is accepted on the following cycle.
- flush=1 in any non-IDLE state: next state IDLE, no done, result/rd_out unchanged. flush together with start in IDLE: the op is not accepted.
- flush in DONE: done still pulses; EX/MEM squashing is the pipeline's responsibility.

Optional Feature:
- Macro MULDIV_PAIR_REUSE_EN.
- Defined:
  - After every completed division, keep the last dividend, divisor, signedness, quotient and remainder plus a valid bit (cleared by reset and flush).
  - A new DIV/DIVU/REM/REMU with identical operands and signedness goes IDLE -> DONE directly (2-cycle latency), taking the quotient or remainder from the saved values.
  - Any MUL-family op leaves the saved values intact.
- Undefined: no reuse storage; every division takes the full path.

Decomposition:
- Shared package riscv_pkg:
  - funct3 encodings MUL..REMU
  - state enum for the six states
  - XLEN constant
  - DIV_ZERO_Q constant (all ones)
- Sub-module div_core: the iterative restoring datapath (remainder, quotient and counter registers; one step per enable). The sequencer owns the FSM, sign handling, special cases and MUL.

Test Plan:
- MUL 7 * -3 (op_a=7, op_b=0xFFFFFFFD), rd_in=5 -> done at cycle 2, result=0xFFFFFFEB, rd_out=5, stall high for cycles 0-1.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV -20/3 -> done at cycle 35, result 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 14.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each in 3 cycles; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- Flush at cycle 10 of a DIV -> no done, busy=0 next cycle, result still holds the previous value. Then reset low mid-DIV -> all outputs 0.
- With MULDIV_PAIR_REUSE_EN: DIV 100/7 then REM 100/7 -> second done after 2 cycles, result 2. Without the macro -> 35 cycles.
